updown_sweep_ctrl: RTL

- Sequencing controller with an integrated up/down count register of WIDTH bits.
- On a start request it loads a programmable low bound, then counts up to a high bound and back down, which is one sweep.
- Repeats for a programmed number of sweeps, then pulses done.
- Sits between a control/CSR source and any logic consuming the counter value and direction (e.g. LED/7-seg display stage); supports pause and abort.

---
 rtl/updown_sweep_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl
// Sequencing controller with an integrated up/down count register.
// An accepted start captures lo/hi/n_sweeps. The count register is then
// loaded with lo and swept lo..hi..lo for n_sweeps sweeps, after which
// done pulses for one cycle.
//
// Optional feature macro: SWEEP_CONT_EN
//   When defined, n_sweeps==0 starts a continuous run. That run ends only
//   on stop or rst, and sweep_cnt wraps.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      run request, sampled only while idle
//   stop       synchronous abort back to idle (no done)
//   pause      level, freezes the sweep while counting
//   lo, hi     sweep bounds, captured on an accepted start
//   n_sweeps   sweep count, captured on an accepted start
//   q          current count value
//   updown     1 while counting up
//   busy       1 while loading or counting
//   done       one-cycle pulse at the end of a finite run
//   err        one-cycle pulse after a rejected start
//   sweep_cnt  completed sweeps in the current run
module updown_sweep_ctrl #(
  parameter int WIDTH    = 3,
  parameter int SWEEPS_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic [WIDTH-1:0]    lo,
  input  logic [WIDTH-1:0]    hi,
  input  logic [SWEEPS_W-1:0] n_sweeps,
  output logic [WIDTH-1:0]    q,
  output logic                updown,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [SWEEPS_W-1:0] sweep_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0]    ONE_W = WIDTH'(1);
  localparam logic [SWEEPS_W-1:0] ONE_S = SWEEPS_W'(1);
  localparam logic [SWEEPS_W-1:0] ZERO_S = '0;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [SWEEPS_W-1:0] n_q, n_d;
  logic [SWEEPS_W-1:0] sc_q, sc_d;
  logic                updown_q, busy_q, done_q, err_q;
  logic                err_d;
  logic                start_ok;
  logic                last_sweep;
  logic [SWEEPS_W-1:0] sc_inc;

  assign sc_inc = sc_q + ONE_S;

`ifdef SWEEP_CONT_EN
  // A zero sweep count means a continuous run, so it never reaches a last sweep.
  assign start_ok   = (lo < hi);
  assign last_sweep = (n_q != ZERO_S) && (sc_inc == n_q);
`else
  assign start_ok   = (lo < hi) && (n_sweeps != ZERO_S);
  assign last_sweep = (sc_inc == n_q);
`endif

  // Next-state and datapath logic for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    n_d     = n_q;
    sc_d    = sc_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            lo_d    = lo;
            hi_d    = hi;
            n_d     = n_sweeps;
            sc_d    = ZERO_S;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = lo_q;
          state_d = S_UP;
        end
      end
      S_UP: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (pause) begin
          state_d = S_UP;
        end else if (cnt_q == hi_q) begin
          cnt_d   = cnt_q - ONE_W;
          state_d = S_DOWN;
        end else begin
          cnt_d = cnt_q + ONE_W;
        end
      end
      S_DOWN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (pause) begin
          state_d = S_DOWN;
        end else if (cnt_q != lo_q) begin
          cnt_d = cnt_q - ONE_W;
        end else begin
          // lo reached: one sweep complete. Either finish at lo or turn upward.
          sc_d = sc_inc;
          if (last_sweep) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + ONE_W;
            state_d = S_UP;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, captured configuration, and registered outputs.
  // Flags are derived from the next state so that they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      n_q      <= '0;
      sc_q     <= '0;
      updown_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      n_q      <= n_d;
      sc_q     <= sc_d;
      updown_q <= (state_d == S_UP);
      busy_q   <= (state_d == S_LOAD) || (state_d == S_UP) || (state_d == S_DOWN);
      done_q   <= (state_d == S_DONE);
      err_q    <= err_d;
    end
  end

  assign q         = cnt_q;
  assign updown    = updown_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign sweep_cnt = sc_q;

endmodule
